// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: host command/response channels plus APB requester bus for apb_master_bridge.
interface apb_master_bridge_if #(parameter int ADDR_WIDTH = 8, parameter int DATA_WIDTH = 32);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_slverr;
  logic                  rsp_timeout;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, psel, penable, pwrite, paddr, pwdata
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB requester driven by a valid/ready command/response host channel.
// Optional ACCESS-phase watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                    pclk,
  input logic                    preset_n,
  apb_master_bridge_if.master    bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t                r_state;
  logic                  r_init_done;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_slverr;
  logic                  w_cmd_ready;
  assign w_cmd_ready    = (r_state == IDLE) && r_init_done;
  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.psel       = r_psel;
  assign bus.penable    = r_penable;
  assign bus.pwrite     = r_pwrite;
  assign bus.paddr      = r_paddr;
  assign bus.pwdata     = r_pwdata;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_rdata  = r_rsp_rdata;
  assign bus.rsp_slverr = r_rsp_slverr;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          r_rsp_timeout;
  logic          w_expire;
  // Abort on the wait cycle that would bring the count to TIMEOUT_CYCLES.
  assign w_expire        = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign bus.rsp_timeout = r_rsp_timeout;
`else
  assign bus.rsp_timeout = 1'b0;
`endif
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state      <= IDLE;
      r_init_done  <= 1'b0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_slverr <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      r_cnt         <= '0;
      r_rsp_timeout <= 1'b0;
`endif
    end else begin
      r_init_done <= 1'b1;
      case (r_state)
        IDLE: if (bus.cmd_valid && w_cmd_ready) begin
          r_pwrite <= bus.cmd_write;
          r_paddr  <= bus.cmd_addr;
          r_pwdata <= bus.cmd_wdata;
          r_psel   <= 1'b1;
          r_state  <= SETUP;
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          r_cnt     <= '0;
`endif
        end
        ACCESS: begin
          if (bus.pready) begin
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_rsp_rdata  <= r_pwrite ? '0 : bus.prdata;
            r_rsp_slverr <= bus.pslverr;
            r_rsp_valid  <= 1'b1;
            r_state      <= RESP;
`ifdef APB_MASTER_TIMEOUT_EN
            r_rsp_timeout <= 1'b0;
`endif
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (w_expire) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_slverr  <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_state       <= RESP;
          end else r_cnt <= r_cnt + 1'b1;
`endif
        end
        RESP: if (bus.rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed vector bench with a small register-block APB slave model.
module tb_apb_master_bridge;
  logic pclk;
  logic preset_n;
  int   passed;
  int   total;
  int   wait_n;
  int   acc_cnt;
  logic [31:0] reg0;
  logic [31:0] reg8;
  apb_master_bridge_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();
  apb_master_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .preset_n(preset_n), .bus(bus)
  );
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end
  // Register-block slave: 0x00 rw, 0x04 ro {ABCD, reg0[15:0]}, 0x08 rw, others error.
  assign bus.pready = bus.psel && bus.penable && (acc_cnt == wait_n);
  always_comb begin
    bus.prdata  = 32'hDEAD_BEEF;
    bus.pslverr = 1'b1;
    if (bus.paddr == 8'h00) begin bus.prdata = reg0; bus.pslverr = 1'b0; end
    if (bus.paddr == 8'h04) begin bus.prdata = {16'hABCD, reg0[15:0]}; bus.pslverr = 1'b0; end
    if (bus.paddr == 8'h08) begin bus.prdata = reg8; bus.pslverr = 1'b0; end
  end
  always @(posedge pclk) begin
    acc_cnt <= (bus.psel && bus.penable && !bus.pready) ? acc_cnt + 1 : 0;
    if (bus.psel && bus.penable && bus.pready && bus.pwrite) begin
      if (bus.paddr == 8'h00) reg0 <= bus.pwdata;
      if (bus.paddr == 8'h08) reg8 <= bus.pwdata;
    end
  end
  typedef struct {
    logic        w;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          waits;
    int          exp_acc;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        exp_to;
  } vec_t;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic wait_accept();
    int n = 0;
    while (!bus.cmd_ready && n < 40) begin @(negedge pclk); n++; end
    chk("accept_in_time", 32'(n < 40), 1);
  endtask
  task automatic wait_rsp(output int n);
    n = 0;
    while (!bus.rsp_valid && n < 60) begin @(negedge pclk); n++; end
  endtask
  task automatic xfer(input vec_t v);
    int n;
    int bad;
    wait_n = v.waits;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.w;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    wait_accept();
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    chk("setup_psel", 32'(bus.psel), 1);
    chk("setup_penable", 32'(bus.penable), 0);
    @(negedge pclk);
    n = 0;
    bad = 0;
    while (!bus.rsp_valid && n < 60) begin
      if (!(bus.psel && bus.penable && bus.paddr == v.addr && bus.pwrite == v.w && bus.cmd_ready == 1'b0)) bad++;
      n++;
      @(negedge pclk);
    end
    chk("access_cycles", 32'(n), 32'(v.exp_acc));
    chk("access_hold", 32'(bad), 0);
    chk("rsp_rdata", bus.rsp_rdata, v.exp_rd);
    chk("rsp_slverr", 32'(bus.rsp_slverr), 32'(v.exp_err));
    chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(v.exp_to));
    chk("resp_psel_low", 32'({bus.psel, bus.penable}), 0);
    bus.rsp_ready = 1'b1;
    @(negedge pclk);
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", 32'(bus.rsp_valid), 0);
    chk("paddr_held", 32'(bus.paddr), 32'(v.addr));
  endtask
  vec_t vecs[7];
  initial begin
    int n;
    int hold;
    vec_t tov;
    passed = 0;
    total  = 0;
    wait_n = 0;
    acc_cnt = 0;
    reg0 = 32'h0;
    reg8 = 32'h0;
    vecs[0] = '{1'b1, 8'h08, 32'h1234_5678, 0, 1, 32'h0,         1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h08, 32'h0,         0, 1, 32'h1234_5678, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h00, 32'h0000_005A, 0, 1, 32'h0,         1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h04, 32'h0,         0, 1, 32'hABCD_005A, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h10, 32'h0,         0, 1, 32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h08, 32'h0,         3, 4, 32'h1234_5678, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h0C, 32'hFFFF_FFFF, 1, 2, 32'h0,         1'b1, 1'b0};
    preset_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge pclk);
    chk("reset_bus", 32'({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout}), 0);
    chk("reset_paddr", 32'(bus.paddr), 0);
    chk("reset_rdata", bus.rsp_rdata, 0);
    chk("reset_cmd_ready", 32'(bus.cmd_ready), 0);
    preset_n = 1'b1;
    #1 chk("init_not_done", 32'(bus.cmd_ready), 0);
    @(negedge pclk);
    chk("init_done_ready", 32'(bus.cmd_ready), 1);
    foreach (vecs[i]) xfer(vecs[i]);
    // Response backpressure with a second command waiting behind it.
    wait_n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h08;
    wait_accept();
    @(negedge pclk);
    bus.cmd_addr = 8'h00;
    wait_rsp(n);
    chk("bp_rsp_valid", 32'(bus.rsp_valid), 1);
    hold = 0;
    repeat (5) begin
      if (!(bus.rsp_valid && bus.rsp_rdata == 32'h1234_5678 && !bus.cmd_ready && !bus.psel)) hold++;
      @(negedge pclk);
    end
    chk("bp_hold", 32'(hold), 0);
    bus.rsp_ready = 1'b1;
    @(negedge pclk);
    bus.rsp_ready = 1'b0;
    chk("bp_rsp_drop", 32'(bus.rsp_valid), 0);
    chk("bp_ready_again", 32'(bus.cmd_ready), 1);
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    chk("bp_second_setup", 32'({bus.psel, bus.penable}), 32'b10);
    chk("bp_second_addr", 32'(bus.paddr), 0);
    wait_rsp(n);
    chk("bp_second_rdata", bus.rsp_rdata, 32'h0000_005A);
    bus.rsp_ready = 1'b1;
    @(negedge pclk);
    bus.rsp_ready = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    tov = '{1'b0, 8'h08, 32'h0, 1000, 16, 32'h0, 1'b1, 1'b1};
    xfer(tov);
`endif
    // Reset in the middle of a wait-stated ACCESS.
    wait_n = 10;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h08;
    wait_accept();
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge pclk);
    chk("mid_access", 32'({bus.psel, bus.penable}), 32'b11);
    preset_n = 1'b0;
    #1 chk("mid_reset_bus", 32'({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready}), 0);
    @(negedge pclk);
    preset_n = 1'b1;
    #1 chk("post_reset_not_ready", 32'(bus.cmd_ready), 0);
    @(negedge pclk);
    chk("post_reset_ready", 32'(bus.cmd_ready), 1);
    chk("post_reset_no_rsp", 32'(bus.rsp_valid), 0);
    tov = '{1'b0, 8'h08, 32'h0, 0, 1, 32'h1234_5678, 1'b0, 1'b0};
    xfer(tov);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
APB requester (initiator) that converts single-beat commands from an internal host into APB transfers. It drives the same APB bus that the team's register-block slaves respond on. Uses a valid/ready command channel in and a valid/ready response channel out. Exactly one transfer is outstanding at a time.

Parameters:
ADDR_WIDTH, 8, width of cmd_addr/paddr
DATA_WIDTH, 32, width of write/read data
TIMEOUT_CYCLES, 16, max ACCESS cycles before abort (used only with the optional feature; must be >= 1)

Ports:
pclk  input  1  clock; all logic on rising edge
preset_n  input  1  reset, asynchronous, active-low
cmd_valid  input  1  host presents a command
cmd_ready  output  1  bridge accepts the command this cycle
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_WIDTH  transfer address
cmd_wdata  input  DATA_WIDTH  write data (ignored for reads)
rsp_valid  output  1  response available
rsp_ready  input  1  host consumes the response
rsp_rdata  output  DATA_WIDTH  captured read data (0 for writes)
rsp_slverr  output  1  captured pslverr (or timeout)
rsp_timeout  output  1  transfer aborted by timeout
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
paddr  output  ADDR_WIDTH  APB address
pwdata  output  DATA_WIDTH  APB write data
prdata  input  DATA_WIDTH  APB read data
pready  input  1  APB ready / wait-state
pslverr  input  1  APB slave error

Behaviour:
- Reset (preset_n low, async): state = IDLE. psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout = 0. cmd_ready = 0.
- cmd_ready = (state == IDLE) && init_done. init_done is a flop, reset 0, set at the first pclk edge after reset release.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_valid && cmd_ready -> latch write/addr/wdata into pwrite/paddr/pwdata; next state SETUP.
- SETUP (exactly 1 cycle): psel=1, penable=0; next state ACCESS.
- ACCESS: psel=1, penable=1. pwrite/paddr/pwdata held stable. pready is sampled each cycle:
  - pready=0: stay in ACCESS (wait state, unlimited unless timeout is enabled).
  - pready=1: rsp_rdata <= pwrite ? 0 : prdata; rsp_slverr <= pslverr; rsp_timeout <= 0; next state RESP.
- psel/penable are registered outputs. They are 0 in the cycle after pready is sampled high.
- RESP: rsp_valid=1. rsp_* held stable until rsp_ready=1, then next state IDLE.
- cmd_ready is 0 outside IDLE. Commands presented during SETUP/ACCESS/RESP are not accepted, and the host holds them.
- Minimum accept-to-accept spacing: 4 cycles (IDLE, SETUP, ACCESS with zero wait, RESP with rsp_ready=1).
- pready and pslverr are ignored outside ACCESS. prdata is captured only on the ACCESS cycle with pready=1.
- paddr/pwdata/pwrite hold their last values in IDLE/RESP. No bus toggling between transfers.
- rsp_rdata/rsp_slverr/rsp_timeout hold their values after RESP until the next capture.
- Reset mid-transfer (any state): psel/penable drop immediately. No response is issued, and the pending command is lost.
- rsp_ready while rsp_valid=0 is ignored.

Optional Feature:
APB_MASTER_TIMEOUT_EN
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT_CYCLES with pready still 0, the transfer aborts: psel/penable=0 next cycle, rsp_rdata=0, rsp_slverr=1, rsp_timeout=1, next state RESP.
  - pready=1 on the same cycle the limit is hit takes priority and completes normally.
- Undefined: no counter is built, rsp_timeout is tied to 0, and wait states are unbounded.

Test Plan:
- Write 0x08 data 0x1234_5678, then read 0x08, against the register-block slave, zero wait -> read rsp_rdata=0x1234_5678, rsp_slverr=0. Each transfer shows SETUP (psel=1, penable=0) for exactly 1 cycle before ACCESS.
- Write 0x00 data 0x0000_005A, then read 0x04 -> rsp_rdata=0xABCD_005A, slverr=0. Write response has rsp_rdata=0.
- Read 0x10 (unmapped) -> rsp_slverr=1, rsp_rdata=0xDEAD_BEEF. The next command is accepted normally.
- Slave model holds pready=0 for 3 cycles -> psel/penable/paddr stable for 4 ACCESS cycles. rsp_valid asserts the cycle after pready=1.
- rsp_ready held 0 for 5 cycles with a second cmd_valid pending -> rsp_valid and data held, cmd_ready=0 throughout. The second command is accepted 1 cycle after rsp_ready.
- With APB_MASTER_TIMEOUT_EN and pready stuck 0 -> abort after 16 wait cycles with rsp_slverr=1, rsp_timeout=1. Separately, preset_n pulsed low mid-ACCESS -> psel=0 immediately, no rsp_valid, and cmd_ready returns 1 cycle after reset release.
